uart_frame_accumulator: RTL and testbench

//   Collects a frame of up to DEPTH bytes from the UART receiver strobe, keeping a running
//   sum of SUM_WIDTH bits. When the frame closes it replies through the UART transmitter

---
 rtl/uart_frame_accumulator.sv | 153 +++++++++++++++
 tb/tb_uart_frame_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_accumulator.sv
// Frame accumulator between uart_rx and uart_tx: buffers up to DEPTH bytes with a
// running sum, then replies with the sum (LSB byte first) or an echo of the frame.
module uart_frame_accumulator #(
  parameter int N_DATA_BITS = 8,
  parameter int DEPTH       = 16,
  parameter int SUM_WIDTH   = N_DATA_BITS + $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_DATA_BITS-1:0]     i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_flush,
  input  logic                       i_mode,
  input  logic                       i_tx_ready,
  output logic [N_DATA_BITS-1:0]     o_tx_data,
  output logic                       o_tx_valid,
  output logic [SUM_WIDTH-1:0]       o_sum,
  output logic [SUM_WIDTH-1:0]       o_last_sum,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_busy,
  output logic                       o_overrun
);

  localparam int SUM_BYTES = (SUM_WIDTH + N_DATA_BITS - 1) / N_DATA_BITS;
  localparam int SUM_EXT_W = SUM_BYTES * N_DATA_BITS;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int AW        = $clog2(DEPTH);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    SEND_SUM  = 2'd1,
    SEND_ECHO = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [SUM_WIDTH-1:0]   last_sum_q, last_sum_d;
  logic                   overrun_q, overrun_d;
  logic [N_DATA_BITS-1:0] mem_q [DEPTH];

  logic                   wr_en;
  logic [CW-1:0]          acc_count;
  logic [SUM_WIDTH-1:0]   acc_sum;
  logic [SUM_EXT_W-1:0]   sum_ext;
  logic                   tx_valid;
  logic [N_DATA_BITS-1:0] tx_data;

  // Top reply byte is zero-padded when SUM_WIDTH is not a whole number of bytes.
  assign sum_ext = SUM_EXT_W'(sum_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    last_sum_d = last_sum_q;
    overrun_d  = overrun_q;
    wr_en      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    // Count and sum as they stand once a same-cycle rx byte is folded in.
    acc_count  = count_q + CW'(i_rx_valid);
    acc_sum    = i_rx_valid ? sum_q + SUM_WIDTH'(i_rx_data) : sum_q;

    case (state_q)
      COLLECT: begin
        if (i_rx_valid) begin
          wr_en   = 1'b1;
          count_d = acc_count;
          sum_d   = acc_sum;
        end
        if ((i_rx_valid && count_q == CW'(DEPTH - 1)) ||
            (i_flush && acc_count != '0)) begin
          last_sum_d = acc_sum;
          idx_d      = '0;
          state_d    = i_mode ? SEND_ECHO : SEND_SUM;
        end
      end
      SEND_SUM: begin
        tx_valid = 1'b1;
        tx_data  = sum_ext[idx_q*N_DATA_BITS +: N_DATA_BITS];
        if (i_tx_ready) begin
          if (idx_q == CW'(SUM_BYTES - 1)) begin
            state_d = COLLECT;
            count_d = '0;
            sum_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      SEND_ECHO: begin
        tx_valid = 1'b1;
        tx_data  = mem_q[idx_q[AW-1:0]];
        if (i_tx_ready) begin
          if (idx_q == count_q - CW'(1)) begin
            state_d = COLLECT;
            count_d = '0;
            sum_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    if (state_q != COLLECT && i_rx_valid) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= COLLECT;
      count_q    <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      last_sum_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      last_sum_q <= last_sum_d;
      overrun_q  <= overrun_d;
    end
  end

  // NOTE: the byte buffer has no reset; entries are only read after being written
  // in the current frame, so resetting it would just cost reset fan-out.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= i_rx_data;
    end
  end

  assign o_tx_data  = tx_data;
  assign o_tx_valid = tx_valid;
  assign o_sum      = sum_q;
  assign o_last_sum = last_sum_q;
  assign o_count    = count_q;
  assign o_busy     = (state_q != COLLECT);
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_frame_accumulator.sv
// Directed bench for uart_frame_accumulator: a table of whole frames plus hand-written
// sequences for backpressure, overrun, empty flush and reset mid-reply.
module tb_uart_frame_accumulator;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        flush;
  logic        mode;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [11:0] sum;
  logic [11:0] last_sum;
  logic [4:0]  count;
  logic        busy;
  logic        overrun;

  int tests_run = 0;
  int tests_failed = 0;

  uart_frame_accumulator dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_flush    (flush),
    .i_mode     (mode),
    .i_tx_ready (tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_sum      (sum),
    .o_last_sum (last_sum),
    .o_count    (count),
    .o_busy     (busy),
    .o_overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flush: 0 = none, 1 = with the last byte, 2 = separate cycle after the last byte
  typedef struct {
    string        name;
    logic         mode;
    int           n;
    logic [127:0] data;
    int           flush;
    logic [11:0]  exp_last;
    int           n_tx;
    logic [127:0] exp_tx;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the negedge; outputs are checked on the negedge before driving.
  task automatic send_bytes(input int n, input logic [127:0] data, input logic fl_last);
    for (int i = 0; i < n; i++) begin
      rx_data  = data[i*8 +: 8];
      rx_valid = 1'b1;
      flush    = fl_last && (i == n - 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    mode     = v.mode;
    tx_ready = 1'b1;
    send_bytes(v.n, v.data, v.flush == 1);
    if (v.flush == 2) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    check({v.name, " reply_start"}, {31'd0, tx_valid}, 32'd1);
    check({v.name, " last_sum"}, {20'd0, last_sum}, {20'd0, v.exp_last});
    for (int k = 0; k < v.n_tx; k++) begin
      check($sformatf("%s tx%0d", v.name, k), {23'd0, tx_valid, tx_data},
            {23'd0, 1'b1, v.exp_tx[k*8 +: 8]});
      @(negedge clk);
    end
    check({v.name, " valid_drop"}, {31'd0, tx_valid}, 32'd0);
    check({v.name, " count_clr"}, {27'd0, count}, 32'd0);
    check({v.name, " sum_clr"}, {20'd0, sum}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"seq16",  1'b0, 16, 128'h100F0E0D0C0B0A090807060504030201, 0, 12'h088, 2, 128'h0088};
    vecs[1] = '{"allff",  1'b0, 16, {128{1'b1}},                          0, 12'hFF0, 2, 128'h0FF0};
    vecs[2] = '{"echo3",  1'b1, 3,  128'hC3B2A1,                          2, 12'h216, 3, 128'hC3B2A1};
    vecs[3] = '{"echo2s", 1'b1, 2,  128'h2010,                            1, 12'h030, 2, 128'h2010};
    vecs[4] = '{"sum1s",  1'b0, 1,  128'h7F,                              1, 12'h07F, 2, 128'h007F};

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; flush = 1'b0; mode = 1'b0; tx_ready = 1'b0;
    #1;
    check("reset outputs", {tx_valid, tx_data, sum, last_sum, count, busy, overrun},
          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Backpressure: data held at 0x88 for 5 stalled cycles; flush/mode ignored while busy.
    mode = 1'b0; tx_ready = 1'b0;
    send_bytes(16, vecs[0].data, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold%0d", c), {23'd0, tx_valid, tx_data}, {23'd0, 9'h188});
      mode  = (c == 0);
      flush = (c == 0);
      @(negedge clk);
      flush = 1'b0;
    end
    mode = 1'b0; tx_ready = 1'b1;
    check("bp byte0", {23'd0, tx_valid, tx_data}, {23'd0, 9'h188});
    @(negedge clk);
    check("bp byte1", {23'd0, tx_valid, tx_data}, {23'd0, 9'h100});
    @(negedge clk);
    check("bp done", {30'd0, tx_valid, busy}, 32'd0);
    check("bp last_sum", {20'd0, last_sum}, 32'h088);

    // Flush of an empty frame produces no reply.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("empty flush%0d", c), {30'd0, tx_valid, busy}, 32'd0);
      @(negedge clk);
    end

    // Overrun: 0x55 arrives while replying to a 0x05 frame.
    tx_ready = 1'b0;
    send_bytes(1, 128'h05, 1'b1);
    check("ovr pre", {31'd0, overrun}, 32'd0);
    rx_data = 8'h55; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("ovr set", {31'd0, overrun}, 32'd1);
    tx_ready = 1'b1;
    check("ovr byte0", {23'd0, tx_valid, tx_data}, {23'd0, 9'h105});
    @(negedge clk);
    check("ovr byte1", {23'd0, tx_valid, tx_data}, {23'd0, 9'h100});
    @(negedge clk);
    check("ovr sum_clr", {20'd0, sum, count, tx_valid}, 32'd0);
    send_bytes(1, 128'h03, 1'b1);
    check("ovr next last_sum", {20'd0, last_sum}, 32'h003);
    check("ovr next byte0", {23'd0, tx_valid, tx_data}, {23'd0, 9'h103});
    @(negedge clk);
    @(negedge clk);
    check("ovr sticky", {30'd0, overrun, tx_valid}, 32'd2);

    // Reset after the first reply byte has been accepted.
    mode = 1'b0; tx_ready = 1'b1;
    send_bytes(16, vecs[0].data, 1'b0);
    check("rst byte0", {23'd0, tx_valid, tx_data}, {23'd0, 9'h188});
    @(negedge clk);
    check("rst byte1", {23'd0, tx_valid, tx_data}, {23'd0, 9'h100});
    #1 rst = 1'b1;
    #1;
    check("rst mid-reply", {tx_valid, tx_data, sum, last_sum, count, busy, overrun},
          32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst no resume", {30'd0, tx_valid, busy}, 32'd0);
    run_frame(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
